// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
//   Round-robin scheduler in front of a NUM_CH:1 x DATA_W channel mux. It picks
//   one requesting channel, drives the mux select, samples the mux output one
//   cycle later and offers the word on a valid/ready port together with its
//   channel index. Each sampled channel gets a one-cycle acknowledge pulse.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   req        in   NUM_CH   per-channel service request (level)
//   sel        out  SEL_W    registered mux select
//   mux_out    in   DATA_W   mux output for the current sel
//   out_valid  out  1        out_data/out_ch hold a word
//   out_ready  in   1        downstream accept (used only while holding a word)
//   out_data   out  DATA_W   sampled mux word
//   out_ch     out  SEL_W    channel index of out_data
//   ack        out  NUM_CH   one-hot, one-cycle pulse for the sampled channel
// ---------------------------------------------------------------------------
module mux_rr_scheduler #(
    parameter int NUM_CH = 32,
    parameter int SEL_W  = 5,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic [NUM_CH-1:0] ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAMPLE = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    localparam logic [SEL_W-1:0] SEL_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [SEL_W-1:0]    ptr_r;
    logic [SEL_W-1:0]    sel_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [SEL_W-1:0]    out_ch_r;
    logic [NUM_CH-1:0]   ack_r;

    logic [SEL_W-1:0]    grant_s;
    logic                found_s;
    logic [SEL_W-1:0]    scan_idx_s;

    // One-hot decode of a channel index.
    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] vec;
        vec      = {NUM_CH{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin grant: first set request scanning upward from ptr_r, wrapping.
    // The index sum is SEL_W bits wide, so it wraps NUM_CH-1 -> 0 naturally.
    always_comb begin
        grant_s    = ptr_r;
        found_s    = 1'b0;
        scan_idx_s = ptr_r;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx_s = ptr_r + SEL_W'(i);
            if (!found_s && req[scan_idx_s]) begin
                grant_s = scan_idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {SEL_W{1'b0}};
            sel_r       <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            ack_r       <= {NUM_CH{1'b0}};
        end else begin
            // ack is a single-cycle pulse; only the SAMPLE edge raises it
            ack_r <= {NUM_CH{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        sel_r    <= grant_s;
                        out_ch_r <= grant_s;
                        state_r  <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // committed even if the request has since dropped
                    out_data_r  <= mux_out;
                    out_valid_r <= 1'b1;
                    ack_r       <= onehot(sel_r);
                    state_r     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                        // serviced channel becomes lowest priority next round
                        ptr_r       <= out_ch_r + SEL_ONE;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign ack       = ack_r;

endmodule
